// File: rtl/fpga_mem_c_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : fpga_mem_c_stream_reader
// Purpose  : Avalon-MM read master for the 256-bit s2 port of the Mem_C
//            buffer. A (base, length) command becomes back-to-back single
//            word reads. The words are emitted on an Avalon-ST source with
//            ready/valid backpressure.
//            The s2 port has a fixed 1-cycle read latency and no
//            waitrequest. Backpressure is therefore absorbed by a small
//            skid FIFO. Reads are only issued when the FIFO is guaranteed
//            to have room for the returning word (credit-based issue).
// Ports    :
//   clk, reset_n               clock, asynchronous active-low reset
//   cmd_start/base/len/abort   command interface (accepted only in IDLE)
//   busy, done                 status: busy while not IDLE,
//                              done is a one-cycle completion pulse
//   mem_*                      s2 read master: address, chipselect,
//                              write, byteenable, clken, readdata
//   st_data/valid/ready/sop/eop  Avalon-ST source
// Revision : 1.0 - initial release
// ============================================================================
module fpga_mem_c_stream_reader #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 256,
    parameter int LEN_W      = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  cmd_start,
    input  logic [ADDR_W-1:0]     cmd_base,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic                  cmd_abort,
    output logic                  busy,
    output logic                  done,

    output logic [ADDR_W-1:0]     mem_address,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata,

    output logic [DATA_W-1:0]     st_data,
    output logic                  st_valid,
    input  logic                  st_ready,
    output logic                  st_sop,
    output logic                  st_eop
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  done_q, done_d;

    logic [ADDR_W-1:0]     base_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      issued_q;

    // One read may be in flight. Its sop/eop tags travel alongside it.
    logic                  inflight_q;
    logic                  ret_sop_q;
    logic                  ret_eop_q;

    // Skid FIFO storage and bookkeeping
    logic [DATA_W-1:0]     fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_sop_q;
    logic [FIFO_DEPTH-1:0] fifo_eop_q;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;

    logic                  fifo_empty;
    logic                  credit_ok;
    logic                  issue;
    logic                  last_issue;
    logic                  accept_cmd;
    logic                  zero_cmd;
    logic                  abort;
    logic                  push;
    logic                  pop;
    logic                  head_sop;
    logic                  head_eop;
    logic                  last_accept;

    // ------------------------------------------------------------------
    // Issue / command decode
    // ------------------------------------------------------------------
    assign fifo_empty = (count_q == '0);
    // Words already owed to the FIFO (stored + in flight) must leave
    // room for the one about to be requested.
    assign credit_ok  = (count_q + CNT_W'(inflight_q)) < CNT_W'(FIFO_DEPTH);
    assign issue      = (state_q == S_RUN) && (issued_q < len_q) && credit_ok;
    assign last_issue = issue && (issued_q == (len_q - LEN_W'(1)));
    assign accept_cmd = (state_q == S_IDLE) && cmd_start && (cmd_len != '0);
    assign zero_cmd   = (state_q == S_IDLE) && cmd_start && (cmd_len == '0);
    assign abort      = cmd_abort && (state_q != S_IDLE);

    // ------------------------------------------------------------------
    // Stream head
    // ------------------------------------------------------------------
    // When the FIFO is empty the returning word is shown directly. If
    // it is accepted in that same cycle, the push and pop cancel out.
    // Otherwise it lands in the FIFO and stays at the head, so st_data
    // does not change while stalled.
    assign push     = inflight_q;
    assign st_valid = !fifo_empty || inflight_q;
    assign pop      = st_valid && st_ready;
    assign st_data  = fifo_empty ? mem_readdata : fifo_data_q[rd_ptr_q];
    assign head_sop = fifo_empty ? ret_sop_q    : fifo_sop_q[rd_ptr_q];
    assign head_eop = fifo_empty ? ret_eop_q    : fifo_eop_q[rd_ptr_q];
    assign st_sop   = st_valid && head_sop;
    assign st_eop   = st_valid && head_eop;

    assign last_accept = (state_q == S_DRAIN) && pop && head_eop;

    // ------------------------------------------------------------------
    // Memory master outputs
    // ------------------------------------------------------------------
    assign mem_chipselect = issue;
    assign mem_address    = issue ? (base_q + issued_q[ADDR_W-1:0]) : '0;
    assign mem_write      = 1'b0;
    assign mem_byteenable = '1;
    assign mem_clken      = 1'b1;

    assign busy = (state_q != S_IDLE);
    assign done = done_q;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_cmd) begin
                    state_d = S_RUN;
                end
                if (zero_cmd) begin
                    done_d = 1'b1;
                end
            end
            S_RUN: begin
                if (last_issue) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_accept) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Abort wins over a same-cycle final handshake and never reports done.
        if (abort) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Command, issue and FIFO bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            inflight_q <= 1'b0;
            ret_sop_q  <= 1'b0;
            ret_eop_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else if (abort) begin
            // Flush everything. The in-flight return is dropped by
            // clearing inflight_q, so it is never pushed.
            issued_q   <= '0;
            inflight_q <= 1'b0;
            ret_sop_q  <= 1'b0;
            ret_eop_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            if (accept_cmd) begin
                base_q   <= cmd_base;
                len_q    <= cmd_len;
                issued_q <= '0;
            end else if (issue) begin
                issued_q <= issued_q + LEN_W'(1);
            end

            inflight_q <= issue;
            ret_sop_q  <= issue && (issued_q == '0);
            ret_eop_q  <= last_issue;

            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage: the returning word is always captured. The pointers
    // alone decide whether it is live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= mem_readdata;
            fifo_sop_q[wr_ptr_q]  <= ret_sop_q;
            fifo_eop_q[wr_ptr_q]  <= ret_eop_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpga_mem_c_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpga_mem_c_stream_reader
// Purpose  : Self-checking bench for fpga_mem_c_stream_reader.
//            - A table of transfer commands is applied one after another.
//              Each entry gives the expected first-valid latency and the
//              expected done cycle.
//            - Hand-written sequences cover reset, abort and an
//              asynchronous reset asserted mid-transfer.
//            - Memory words are a pure function of their address, so the
//              expected data follows directly from base + word index.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpga_mem_c_stream_reader;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 256;
    localparam int LEN_W  = 12;
    localparam int DEPTH  = 4;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                cmd_start;
    logic [ADDR_W-1:0]   cmd_base;
    logic [LEN_W-1:0]    cmd_len;
    logic                cmd_abort;
    logic                busy;
    logic                done;
    logic [ADDR_W-1:0]   mem_address;
    logic                mem_chipselect;
    logic                mem_write;
    logic [DATA_W/8-1:0] mem_byteenable;
    logic                mem_clken;
    logic [DATA_W-1:0]   mem_readdata;
    logic [DATA_W-1:0]   st_data;
    logic                st_valid;
    logic                st_ready;
    logic                st_sop;
    logic                st_eop;

    int n_cmp = 0;
    int n_err = 0;

    fpga_mem_c_stream_reader #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .LEN_W     (LEN_W),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_start     (cmd_start),
        .cmd_base      (cmd_base),
        .cmd_len       (cmd_len),
        .cmd_abort     (cmd_abort),
        .busy          (busy),
        .done          (done),
        .mem_address   (mem_address),
        .mem_chipselect(mem_chipselect),
        .mem_write     (mem_write),
        .mem_byteenable(mem_byteenable),
        .mem_clken     (mem_clken),
        .mem_readdata  (mem_readdata),
        .st_data       (st_data),
        .st_valid      (st_valid),
        .st_ready      (st_ready),
        .st_sop        (st_sop),
        .st_eop        (st_eop)
    );

    always #5 clk = ~clk;

    // Preloaded buffer contents: every 32-bit lane carries the address.
    function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
        return {8{21'h1ABCD, a}};
    endfunction

    // s2 port model: fixed 1-cycle read latency
    always @(posedge clk) begin
        if (mem_chipselect) begin
            mem_readdata <= word_of(mem_address);
        end
    end

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [LEN_W-1:0]  len;
        int                mode;     // 0: always ready, 1: random + 5-cycle stall
        bit                poke;     // pulse cmd_start mid-transfer (must be ignored)
        int                exp_lat;  // expected first st_valid cycle (0 = none)
        int                exp_done; // expected done cycle (0 = only check eop+1)
    } vec_t;

    vec_t vecs [6];

    // One command from its start cycle (cycle 0) to the done pulse.
    // Inputs change #1 after posedge. Outputs are sampled at negedge.
    task automatic run_xfer(input vec_t v);
        int  n_iss   = 0;
        int  n_acc   = 0;
        int  max_out = 0;
        int  eop_cyc = -1;
        bit  seen_v  = 0;
        bit  got_dn  = 0;
        bit  stalled = 0;
        logic [DATA_W-1:0] held = '0;

        @(posedge clk); #1;
        cmd_start = 1'b1;
        cmd_base  = v.base;
        cmd_len   = v.len;
        cmd_abort = 1'b0;
        st_ready  = 1'b1;
        @(negedge clk);

        for (int cyc = 1; cyc < 300; cyc++) begin
            @(posedge clk); #1;
            cmd_start = 1'b0;
            if (v.poke && cyc == 3) begin
                cmd_start = 1'b1;
                cmd_base  = 11'h555;
                cmd_len   = 12'd3;
            end
            if (v.mode == 0)                      st_ready = 1'b1;
            else if (cyc >= 6 && cyc <= 10)       st_ready = 1'b0;
            else                                  st_ready = 1'($urandom_range(0, 1));
            @(negedge clk);

            if (mem_chipselect) begin
                check("rd_addr", 256'(mem_address), 256'(11'(v.base + 11'(n_iss))));
                n_iss++;
                if (n_iss - n_acc > max_out) max_out = n_iss - n_acc;
            end
            if (stalled) begin
                check("stall_valid", 256'(st_valid), 256'(1));
                check("stall_data", st_data, held);
            end
            if (st_valid && !seen_v) begin
                seen_v = 1;
                if (v.exp_lat != 0) check("first_valid_cyc", 256'(cyc), 256'(v.exp_lat));
            end
            if (st_valid && st_ready) begin
                check("st_data", st_data, word_of(11'(v.base + 11'(n_acc))));
                check("st_sop", 256'(st_sop), 256'(n_acc == 0));
                check("st_eop", 256'(st_eop), 256'(n_acc == int'(v.len) - 1));
                if (n_acc == int'(v.len) - 1) eop_cyc = cyc;
                n_acc++;
            end
            stalled = st_valid && !st_ready;
            held    = st_data;
            if (done) begin
                got_dn = 1;
                check("busy_at_done", 256'(busy), 256'(0));
                if (v.len != 0) check("done_after_eop", 256'(cyc), 256'(eop_cyc + 1));
                if (v.exp_done != 0) check("done_cyc", 256'(cyc), 256'(v.exp_done));
                break;
            end
        end

        check("done_seen", 256'(got_dn), 256'(1));
        check("reads_issued", 256'(n_iss), 256'(v.len));
        check("words_accepted", 256'(n_acc), 256'(v.len));
        check("outstanding_le_depth", 256'(max_out <= DEPTH), 256'(1));
        @(negedge clk);
        check("done_one_cycle", 256'(done), 256'(0));
    endtask

    initial begin
        vec_t v;
        int   n_acc;
        int   abort_cyc;
        bit   aborted;
        bit   saw_done;

        vecs[0] = '{base: 11'h010, len: 12'd8,  mode: 0, poke: 0, exp_lat: 2, exp_done: 10};
        vecs[1] = '{base: 11'h7FE, len: 12'd4,  mode: 0, poke: 0, exp_lat: 2, exp_done: 6};
        vecs[2] = '{base: 11'h020, len: 12'd16, mode: 1, poke: 1, exp_lat: 2, exp_done: 0};
        vecs[3] = '{base: 11'h300, len: 12'd0,  mode: 0, poke: 0, exp_lat: 0, exp_done: 1};
        vecs[4] = '{base: 11'h123, len: 12'd1,  mode: 0, poke: 0, exp_lat: 2, exp_done: 3};
        vecs[5] = '{base: 11'h7FF, len: 12'd3,  mode: 1, poke: 0, exp_lat: 2, exp_done: 0};

        reset_n   = 1'b0;
        cmd_start = 1'b0;
        cmd_base  = '0;
        cmd_len   = '0;
        cmd_abort = 1'b0;
        st_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // ---------------- reset state ----------------
        check("rst_busy",   256'(busy),           256'(0));
        check("rst_done",   256'(done),           256'(0));
        check("rst_cs",     256'(mem_chipselect), 256'(0));
        check("rst_addr",   256'(mem_address),    256'(0));
        check("rst_valid",  256'(st_valid),       256'(0));
        check("rst_sop",    256'(st_sop),         256'(0));
        check("rst_eop",    256'(st_eop),         256'(0));
        check("mem_write",  256'(mem_write),      256'(0));
        check("mem_be",     256'(mem_byteenable), {224'h0, 32'hFFFF_FFFF});
        check("mem_clken",  256'(mem_clken),      256'(1));
        reset_n = 1'b1;

        // ---------------- table-driven transfers ----------------
        for (int i = 0; i < 6; i++) begin
            run_xfer(vecs[i]);
        end

        // ---------------- abort after 10 words ----------------
        @(posedge clk); #1;
        cmd_start = 1'b1;
        cmd_base  = 11'h200;
        cmd_len   = 12'd32;
        st_ready  = 1'b1;
        @(negedge clk);
        n_acc     = 0;
        aborted   = 0;
        abort_cyc = 0;
        saw_done  = 0;
        for (int cyc = 1; cyc < 100; cyc++) begin
            @(posedge clk); #1;
            cmd_start = 1'b0;
            if (n_acc == 10 && !aborted) begin
                cmd_abort = 1'b1;
                st_ready  = 1'b0;
                aborted   = 1;
                abort_cyc = cyc;
            end else begin
                cmd_abort = 1'b0;
                st_ready  = 1'b1;
            end
            @(negedge clk);
            if (done) saw_done = 1;
            if (aborted && cyc == abort_cyc + 1) begin
                check("abort_busy",  256'(busy),     256'(0));
                check("abort_valid", 256'(st_valid), 256'(0));
                check("abort_cs",    256'(mem_chipselect), 256'(0));
                break;
            end
            if (st_valid && st_ready) begin
                check("abort_pre_data", st_data, word_of(11'(11'h200 + 11'(n_acc))));
                n_acc++;
            end
        end
        check("abort_reached", 256'(aborted), 256'(1));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) saw_done = 1;
            check("abort_idle_valid", 256'(st_valid), 256'(0));
        end
        check("abort_no_done", 256'(saw_done), 256'(0));
        check("abort_words", 256'(n_acc), 256'(10));
        v = '{base: 11'h100, len: 12'd2, mode: 0, poke: 0, exp_lat: 2, exp_done: 4};
        run_xfer(v);

        // ---------------- async reset mid-RUN ----------------
        @(posedge clk); #1;
        cmd_start = 1'b1;
        cmd_base  = 11'h040;
        cmd_len   = 12'd8;
        st_ready  = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy",  256'(busy),           256'(0));
        check("arst_cs",    256'(mem_chipselect), 256'(0));
        check("arst_addr",  256'(mem_address),    256'(0));
        check("arst_valid", 256'(st_valid),       256'(0));
        check("arst_sop",   256'(st_sop),         256'(0));
        check("arst_eop",   256'(st_eop),         256'(0));
        check("arst_done",  256'(done),           256'(0));
        @(negedge clk);
        reset_n = 1'b1;
        run_xfer(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
